dkong_col_pal_gen: RTL

Parametrised successor colour-palette stage for the DK-family video path.
- Merges tile and sprite pixel codes with sprite-priority transparency.
- Appends a per-line palette bank to form the palette index.
- Looks up an inverted RGB entry in internal palette RAM and drives blank-gated R/G/B.
- Replaces split-PROM config writes with a streaming loader FSM that has a ready/busy/done handshake.
- Sits between the VRAM/object serialisers and the video DAC/scan-doubler.

---
 rtl/dkong_col_pal_gen_if.sv | 26 ++
 rtl/dkong_col_pal_gen.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/dkong_col_pal_gen_if.sv
// rtl/dkong_col_pal_gen_if.sv - palette loader handshake bundle for dkong_col_pal_gen
interface dkong_col_pal_gen_if #(
  parameter int COL_W = 8
);
  logic             I_CNF_START;
  logic             I_CNF_VALID;
  logic [COL_W-1:0] I_CNF_D;
  logic             O_CNF_BUSY;
  logic             O_CNF_DONE;

  modport master (
    output I_CNF_START,
    output I_CNF_VALID,
    output I_CNF_D,
    input  O_CNF_BUSY,
    input  O_CNF_DONE
  );

  modport slave (
    input  I_CNF_START,
    input  I_CNF_VALID,
    input  I_CNF_D,
    output O_CNF_BUSY,
    output O_CNF_DONE
  );
endinterface

// File: rtl/dkong_col_pal_gen.sv
// rtl/dkong_col_pal_gen.sv - DK colour palette stage with streaming loader (optional DKONG_PAL_FADE_EN)
module dkong_col_pal_gen #(
  parameter int SEL_W  = 6,
  parameter int BANK_W = 2,
  parameter int R_W    = 3,
  parameter int G_W    = 3,
  parameter int B_W    = 2
) (
  input  logic              CLK_6M,
  input  logic              W_1EF_RST,
  input  logic [SEL_W-1:0]  I_VRAM_D,
  input  logic [SEL_W-1:0]  I_OBJ_D,
  input  logic [BANK_W-1:0] I_BANK,
  input  logic              I_CMPBLKn,
`ifdef DKONG_PAL_FADE_EN
  input  logic [2:0]        I_FADE,
`endif
  dkong_col_pal_gen_if.slave cnf,
  output logic [R_W-1:0]    O_R,
  output logic [G_W-1:0]    O_G,
  output logic [B_W-1:0]    O_B
);

  localparam int IDX_W = BANK_W + SEL_W;
  localparam int DEPTH = 2 ** IDX_W;
  localparam int COL_W = R_W + G_W + B_W;
  localparam logic [IDX_W-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Palette RAM has no reset so a loaded palette survives W_1EF_RST.
  logic [COL_W-1:0] pal_ram [DEPTH];

  state_t           state_q, state_d;
  logic [IDX_W-1:0] addr_q, addr_d;
  logic             wr_en;

  logic [SEL_W-1:0] sel;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx1;
  logic             blank1;
  logic [COL_W-1:0] entry2;
  logic             blank2;
  logic [COL_W-1:0] col_pre;
  logic             blank_pre;
  logic [COL_W-1:0] col_vis;
  logic             busy;

  // Sprite wins unless its low two bits mark it transparent.
  assign sel = (I_OBJ_D[1:0] == 2'b00) ? I_VRAM_D : I_OBJ_D;
  assign idx = {I_BANK, sel};

  // Index capture and RAM read, with blank delayed in lockstep.
  always_ff @(posedge CLK_6M or negedge W_1EF_RST) begin
    if (!W_1EF_RST) begin
      idx1   <= '0;
      blank1 <= 1'b0;
      entry2 <= '0;
      blank2 <= 1'b0;
    end else begin
      idx1   <= I_CMPBLKn ? idx : '0;
      blank1 <= I_CMPBLKn;
      entry2 <= pal_ram[idx1];
      blank2 <= blank1;
    end
  end

  // Loader write port; data is stored exactly as streamed.
  always_ff @(posedge CLK_6M) begin
    if (wr_en) begin
      pal_ram[addr_q] <= cnf.I_CNF_D;
    end
  end

  // Loader state and address registers.
  always_ff @(posedge CLK_6M or negedge W_1EF_RST) begin
    if (!W_1EF_RST) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Loader next state: start in IDLE, one write per valid beat, exit after the last entry.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cnf.I_CNF_START) begin
          state_d = ST_LOAD;
          addr_d  = '0;
        end
      end
      ST_LOAD: begin
        if (cnf.I_CNF_VALID) begin
          wr_en = 1'b1;
          if (addr_q == LAST_ADDR) begin
            state_d = ST_DONE;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy           = (state_q == ST_LOAD);
  assign cnf.O_CNF_BUSY = busy;
  assign cnf.O_CNF_DONE = (state_q == ST_DONE);

`ifdef DKONG_PAL_FADE_EN
  // Narrow channels take the top bits of the fade amount.
  localparam int R_SH = (R_W < 3) ? 3 - R_W : 0;
  localparam int G_SH = (G_W < 3) ? 3 - G_W : 0;
  localparam int B_SH = (B_W < 3) ? 3 - B_W : 0;

  logic [COL_W-1:0] col_raw;
  logic [R_W-1:0]   fade_r;
  logic [G_W-1:0]   fade_g;
  logic [B_W-1:0]   fade_b;
  logic [COL_W-1:0] col3;
  logic             blank3;
  int               r_i, g_i, b_i;

  // Saturating per-channel subtract of the fade amount.
  always_comb begin
    col_raw = ~entry2;
    r_i     = int'(col_raw[COL_W-1 -: R_W]) - int'(I_FADE >> R_SH);
    g_i     = int'(col_raw[G_W+B_W-1 -: G_W]) - int'(I_FADE >> G_SH);
    b_i     = int'(col_raw[B_W-1:0]) - int'(I_FADE >> B_SH);
    fade_r  = (r_i < 0) ? '0 : R_W'(r_i);
    fade_g  = (g_i < 0) ? '0 : G_W'(g_i);
    fade_b  = (b_i < 0) ? '0 : B_W'(b_i);
  end

  // Extra output stage holding the faded colour and its blank.
  always_ff @(posedge CLK_6M or negedge W_1EF_RST) begin
    if (!W_1EF_RST) begin
      col3   <= '0;
      blank3 <= 1'b0;
    end else begin
      col3   <= {fade_r, fade_g, fade_b};
      blank3 <= blank2;
    end
  end

  assign col_pre   = col3;
  assign blank_pre = blank3;
`else
  assign col_pre   = ~entry2;
  assign blank_pre = blank2;
`endif

  // Blank gates every bit; a load in progress forces black.
  always_comb begin
    col_vis = '0;
    if (!busy && blank_pre) begin
      col_vis = col_pre;
    end
  end

  assign O_R = col_vis[COL_W-1 -: R_W];
  assign O_G = col_vis[G_W+B_W-1 -: G_W];
  assign O_B = col_vis[B_W-1:0];

endmodule
